// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush control for the 5-stage rv32i pipeline.
// Covers the hazards bypass cannot: load-use, data-memory wait and
// taken-branch squash. Stall/flush outputs are combinational from the
// current state and inputs; state, wait watchdog and perf counter are
// registered.
module hazard_stall_unit #(
    parameter int unsigned TIMEOUT = 256,  // MEM_WAIT cycles before timeout_err (>=2)
    parameter int unsigned PERF_W  = 32    // width of stall_cycles
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs1_s,
    input  logic [4:0]        id_rs2_s,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd_s,
    input  logic              ex_br_taken,
    input  logic              dmem_req,
    input  logic              dmem_resp,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              mem_wb_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [PERF_W-1:0] stall_cycles,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_BUBBLE   = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic                timeout_err_q, timeout_err_d;

    logic memwait;
    logic lu_raw;
    logic lu;

    // Hazard detection: memory wait and load-use (masked while EX holds the bubble)
    always_comb begin
        memwait = dmem_req & ~dmem_resp;
        lu_raw  = ex_mem_read && (ex_rd_s != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1_s == ex_rd_s)) ||
                   (id_uses_rs2 && (id_rs2_s == ex_rd_s)));
        lu      = lu_raw && (state_q != S_BUBBLE);
    end

    // Stall/flush generation with priority memwait > branch > load-use
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (rst_n) begin
            if (memwait) begin
                // Whole pipe frozen; a pending branch stays in EX and acts later.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end else if (ex_br_taken) begin
                // Squash the two younger instructions; lu on the ID one is moot.
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (lu) begin
                // Hold PC and IF/ID one cycle and push a NOP into EX.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end
    end

    // Next-state for FSM, wait watchdog and stall performance counter
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        stall_cycles_d = stall_cycles_q;
        timeout_err_d  = timeout_err_q;

        // The same rules apply in every state; BUBBLE differs only via lu masking,
        // and MEM_WAIT exits through the normal branch/lu evaluation on resp.
        if (memwait) begin
            state_d = S_MEM_WAIT;
        end else if (lu && !ex_br_taken) begin
            state_d = S_BUBBLE;
        end else begin
            state_d = S_RUN;
        end

        if (state_q == S_MEM_WAIT) begin
            if (wait_cnt_q != TIMEOUT_C) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (wait_cnt_d == TIMEOUT_C) begin
                timeout_err_d = 1'b1;
            end
        end else if (memwait) begin
            wait_cnt_d = '0;
        end

        if (pc_stall && (stall_cycles_q != {PERF_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // State, counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values.
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed stimulus for hazard_stall_unit with a
// cycle-level behavioural model compared every cycle, plus literal checks.
module tb_hazard_stall_unit;

    localparam int unsigned TO  = 8;
    localparam int unsigned PW  = 4;
    localparam int          SMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1_s, id_rs2_s, ex_rd_s;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken;
    logic          dmem_req, dmem_resp;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic          if_id_flush, id_ex_flush;
    logic [PW-1:0] stall_cycles;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    hazard_stall_unit #(.TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_s(id_rs1_s), .id_rs2_s(id_rs2_s),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd_s(ex_rd_s), .ex_br_taken(ex_br_taken),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cycles(stall_cycles), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    wire [6:0] dut_ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                          mem_wb_stall, if_id_flush, id_ex_flush};

    // ---------------- behavioural model ----------------
    bit m_after_bubble;  // previous cycle inserted a load-use bubble
    bit m_prev_wait;     // previous cycle was waiting on memory
    int m_waited;        // cycles spent since the wait began (saturating at TO)
    bit m_err;
    int m_stall;

    function automatic logic [6:0] exp_ctl();
        logic mw, lu;
        mw = dmem_req && !dmem_resp;
        lu = ex_mem_read && ex_rd_s != 0 &&
             ((id_uses_rs1 && id_rs1_s == ex_rd_s) || (id_uses_rs2 && id_rs2_s == ex_rd_s)) &&
             !m_after_bubble;
        if (!rst_n)           return 7'b0000000;
        if (mw)               return 7'b1111100;
        if (ex_br_taken)      return 7'b0000011;
        if (lu)               return 7'b1100001;
        return 7'b0000000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_after_bubble = 0; m_prev_wait = 0; m_waited = 0; m_err = 0; m_stall = 0;
        end else begin
            logic [6:0] c;
            bit mw;
            c  = exp_ctl();
            mw = dmem_req && !dmem_resp;
            if (c[6] && m_stall < SMAX) m_stall++;
            if (m_prev_wait) begin
                if (m_waited < int'(TO)) m_waited++;
                if (m_waited == int'(TO)) m_err = 1;
            end else if (mw) begin
                m_waited = 0;
            end
            m_after_bubble = (c == 7'b1100001);
            m_prev_wait    = mw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ctl", 32'(dut_ctl), 32'(exp_ctl()));
            check("model_stall_cycles", 32'(stall_cycles), 32'(m_stall));
            check("model_timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    // Drive one cycle of inputs just after the edge, return at the next negedge
    task automatic cyc(input logic req, input logic resp, input logic br, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2);
        @(posedge clk);
        #1;
        dmem_req = req; dmem_resp = resp; ex_br_taken = br; ex_mem_read = mr;
        ex_rd_s = rd; id_rs1_s = rs1; id_rs2_s = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        @(negedge clk);
    endtask

    task automatic set_idle();
        dmem_req = 0; dmem_resp = 0; ex_br_taken = 0; ex_mem_read = 0;
        ex_rd_s = 0; id_rs1_s = 0; id_rs2_s = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        dmem_req = 1'b1;  // outputs must stay 0 under reset even with a request
        #3;
        check("reset_ctl", 32'(dut_ctl), 32'h0);
        check("reset_stall_cycles", 32'(stall_cycles), 32'h0);
        check("reset_timeout_err", 32'(timeout_err), 32'h0);
        set_idle();
        #9 rst_n = 1'b1;
        cmp_en = 1;

        // Load-use on rs1: one bubble, then masked, then quiet
        cyc(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("lu_rs1", 32'(dut_ctl), 32'b1100001);
        cyc(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("lu_masked_in_bubble", 32'(dut_ctl), 32'h0);
        idle();
        check("lu_after_idle", 32'(dut_ctl), 32'h0);

        // rd==0 never produces load-use
        cyc(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        check("lu_x0", 32'(dut_ctl), 32'h0);

        // Load-use via rs2
        cyc(0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, 1);
        check("lu_rs2", 32'(dut_ctl), 32'b1100001);
        idle();
        check("stall_cnt_after_lu", 32'(stall_cycles), 32'd2);

        // Memory wait for 4 cycles, response on the 5th
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            check("memwait_stall", 32'(dut_ctl), 32'b1111100);
        end
        cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("memwait_resp", 32'(dut_ctl), 32'h0);
        idle();
        check("stall_cnt_after_wait", 32'(stall_cycles), 32'd6);

        // Branch beats load-use; FSM stays in RUN so the next lu still stalls
        cyc(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("br_over_lu", 32'(dut_ctl), 32'b0000011);
        cyc(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("lu_after_br", 32'(dut_ctl), 32'b1100001);
        idle();

        // Branch pending during a 3-cycle wait acts on the response cycle
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            check("br_during_wait", 32'(dut_ctl), 32'b1111100);
        end
        cyc(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("br_on_resp", 32'(dut_ctl), 32'b0000011);
        idle();
        check("stall_cnt_after_br_wait", 32'(stall_cycles), 32'd10);

        // Response without a request is ignored
        cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("resp_no_req", 32'(dut_ctl), 32'h0);

        // Watchdog: no response ever
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            check("timeout_stall", 32'(dut_ctl), 32'b1111100);
            if (i == 9)  check("timeout_not_yet", 32'(timeout_err), 32'h0);
            if (i == 10) check("timeout_set", 32'(timeout_err), 32'h1);
            if (i == 10) check("stall_cnt_saturated", 32'(stall_cycles), 32'd15);
        end
        check("timeout_sticky", 32'(timeout_err), 32'h1);

        // Reset pulse in the middle of the wait clears everything
        #2 rst_n = 1'b0;
        #1;
        check("rst_pulse_ctl", 32'(dut_ctl), 32'h0);
        check("rst_pulse_err", 32'(timeout_err), 32'h0);
        check("rst_pulse_stall_cnt", 32'(stall_cycles), 32'h0);
        set_idle();
        #1 rst_n = 1'b1;
        idle();
        check("post_reset_idle", 32'(dut_ctl), 32'h0);
        cyc(0, 0, 0, 1, 5'd9, 5'd0, 5'd9, 0, 1);
        check("post_reset_lu", 32'(dut_ctl), 32'b1100001);
        idle();
        check("post_reset_stall_cnt", 32'(stall_cycles), 32'd1);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
